// File: rtl/bignum_word_serializer.sv
// -----------------------------------------------------------------------------
// bignum_word_serializer
//
// Purpose:
//   Accepts one TOTAL_BITS-wide operand (ciphertext / modulus) over a
//   valid/ready handshake and emits it as NUM_WORDS words of WORD_BITS over a
//   second valid/ready handshake. Every emitted word carries its index within
//   the operand and a last flag, so downstream word-serial units need no
//   private word counter. The word handshake (word_valid_out & word_ready_in)
//   is the event that advances the downstream word-index counter, keeping both
//   blocks in lockstep.
//
// Parameters:
//   TOTAL_BITS  operand width in bits, integer multiple of WORD_BITS
//   WORD_BITS   output word width in bits
//   NUM_WORDS   (derived) TOTAL_BITS / WORD_BITS, must be >= 2
//
// Ports:
//   clk_in          in   1                   system clock, posedge
//   rst_n_in        in   1                   asynchronous active-low reset
//   data_in         in   TOTAL_BITS          operand to serialize
//   data_valid_in   in   1                   data_in valid
//   data_ready_out  out  1                   serializer can accept an operand
//   word_out        out  WORD_BITS           current output word
//   word_valid_out  out  1                   word_out valid
//   word_ready_in   in   1                   downstream accepts word_out
//   word_index_out  out  $clog2(NUM_WORDS)   index of word_out, 0..NUM_WORDS-1
//   word_last_out   out  1                   final word of the operand
//   busy_out        out  1                   operand in flight
//
// Configuration macro:
//   SERIALIZER_MSW_FIRST_EN  when defined, words are emitted most-significant
//                            first (index 0 = most significant word). When
//                            undefined (default), least-significant first.
//
// Timing:
//   First word is valid the cycle after the operand is accepted. A new
//   operand can be accepted the cycle after the final word handshake, giving
//   NUM_WORDS+1 cycles per operand with word_ready_in held high. All outputs
//   come from registers or state decode; no input reaches an output
//   combinationally.
// -----------------------------------------------------------------------------
module bignum_word_serializer #(
  parameter int TOTAL_BITS = 4096,
  parameter int WORD_BITS  = 32
) (
  input  logic                                        clk_in,
  input  logic                                        rst_n_in,
  input  logic [TOTAL_BITS-1:0]                       data_in,
  input  logic                                        data_valid_in,
  output logic                                        data_ready_out,
  output logic [WORD_BITS-1:0]                        word_out,
  output logic                                        word_valid_out,
  input  logic                                        word_ready_in,
  output logic [$clog2(TOTAL_BITS/WORD_BITS)-1:0]     word_index_out,
  output logic                                        word_last_out,
  output logic                                        busy_out
);

  localparam int NUM_WORDS = TOTAL_BITS / WORD_BITS;
  localparam int IDX_BITS  = $clog2(NUM_WORDS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_ZERO = IDX_BITS'(0);

  // Configuration sanity: a single-word operand has no serialization to do,
  // and a partial trailing word would silently drop operand bits.
  if (NUM_WORDS < 2) begin : g_bad_num_words
    $error("bignum_word_serializer: TOTAL_BITS/WORD_BITS must be >= 2");
  end
  if ((TOTAL_BITS % WORD_BITS) != 0) begin : g_bad_multiple
    $error("bignum_word_serializer: TOTAL_BITS must be a multiple of WORD_BITS");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [TOTAL_BITS-1:0] shift_r;
  logic [TOTAL_BITS-1:0] shift_nxt_s;
  logic [IDX_BITS-1:0]   index_r;
  logic [IDX_BITS-1:0]   index_nxt_s;

  logic                  accept_s;     // operand handshake
  logic                  word_xfer_s;  // word handshake
  logic                  at_last_s;    // current word is the final one

  // Handshake and position decode shared by next-state logic and outputs.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) & data_valid_in;
    word_xfer_s = (state_r == ST_SEND) & word_ready_in;
    at_last_s   = (index_r == LAST_IDX);
  end

  // State, shift register and word index registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
      shift_r <= {TOTAL_BITS{1'b0}};
      index_r <= IDX_ZERO;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      index_r <= index_nxt_s;
    end
  end

  // Next-state logic: load on operand accept, advance on each word handshake.
  // Without a word handshake everything holds, so a stalled word is neither
  // lost nor repeated.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    index_nxt_s = index_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SEND;
          shift_nxt_s = data_in;
          index_nxt_s = IDX_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (word_xfer_s) begin
          if (at_last_s) begin
            // Index returns to zero only through the IDLE re-entry; the
            // shift register is left as-is since word_out is not valid
            // in IDLE.
            state_nxt_s = ST_IDLE;
            index_nxt_s = IDX_ZERO;
          end else begin
            state_nxt_s = ST_SEND;
            index_nxt_s = index_r + IDX_ONE;
`ifdef SERIALIZER_MSW_FIRST_EN
            shift_nxt_s = shift_r << WORD_BITS;
`else
            shift_nxt_s = shift_r >> WORD_BITS;
`endif
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean idle with nothing held.
        state_nxt_s = ST_IDLE;
        shift_nxt_s = {TOTAL_BITS{1'b0}};
        index_nxt_s = IDX_ZERO;
      end
    endcase
  end

  // Output decode: purely from registered state, index and shift register.
  always_comb begin
    data_ready_out = (state_r == ST_IDLE);
    busy_out       = (state_r == ST_SEND);
    word_valid_out = (state_r == ST_SEND);
    word_index_out = index_r;
    word_last_out  = (state_r == ST_SEND) & at_last_s;
`ifdef SERIALIZER_MSW_FIRST_EN
    word_out       = shift_r[TOTAL_BITS-1 -: WORD_BITS];
`else
    word_out       = shift_r[WORD_BITS-1:0];
`endif
  end

endmodule

// File: tb/tb_bignum_word_serializer.sv
module tb_bignum_word_serializer;

  localparam int TB_TOTAL = 128;
  localparam int TB_WORD  = 32;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [127:0] data_in;
  logic         data_valid_in;
  logic         data_ready_out;
  logic [31:0]  word_out;
  logic         word_valid_out;
  logic         word_ready_in;
  logic [1:0]   word_index_out;
  logic         word_last_out;
  logic         busy_out;

  int tests_run = 0;
  int tests_failed = 0;

  bignum_word_serializer #(
    .TOTAL_BITS(TB_TOTAL),
    .WORD_BITS (TB_WORD)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .data_ready_out(data_ready_out),
    .word_out      (word_out),
    .word_valid_out(word_valid_out),
    .word_ready_in (word_ready_in),
    .word_index_out(word_index_out),
    .word_last_out (word_last_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic         dv;
    logic [127:0] data;
    logic         wr;
    logic         e_ready;
    logic         e_valid;
    logic [31:0]  e_word;
    logic [1:0]   e_idx;
    logic         e_last;
    logic         e_busy;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  localparam logic [127:0] OP_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] OP_B = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  localparam logic [127:0] OP_C = 128'h0F0F_0F0F_A5A5_5A5A_7777_8888_9999_0000;

  // Word k of an operand in emission order.
  function automatic logic [31:0] word_of(input logic [127:0] op, input int k);
`ifdef SERIALIZER_MSW_FIRST_EN
    return op[127 - 32*k -: 32];
`else
    return op[32*k +: 32];
`endif
  endfunction

  // Row: inputs applied this cycle, outputs expected before the next edge.
  task automatic add_idle(input logic dv, input logic [127:0] d, input logic wr);
    vt[nv] = '{dv, d, wr, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0};
    nv++;
  endtask

  task automatic add_word(input logic dv, input logic [127:0] d, input logic wr,
                          input logic [127:0] op, input int k);
    vt[nv] = '{dv, d, wr, 1'b0, 1'b1, word_of(op, k), 2'(k), (k == 3), 1'b1};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 32'(data_ready_out), 32'd1);
    chk({tag, ".valid"}, 32'(word_valid_out), 32'd0);
    chk({tag, ".busy"},  32'(busy_out),       32'd0);
    chk({tag, ".last"},  32'(word_last_out),  32'd0);
  endtask

  initial begin
    // Test 2: continuous ready, operand A.
    add_idle(1'b1, OP_A, 1'b1);
    for (int k = 0; k < 4; k++) add_word(1'b0, OP_A, 1'b1, OP_A, k);
    // Test 3: ready pattern 1,0,0,1,... starting with word 0.
    add_idle(1'b1, OP_A, 1'b0);
    add_word(1'b0, OP_A, 1'b1, OP_A, 0);
    add_word(1'b0, OP_A, 1'b0, OP_A, 1);
    add_word(1'b0, OP_A, 1'b0, OP_A, 1);
    add_word(1'b0, OP_A, 1'b1, OP_A, 1);
    add_word(1'b0, OP_A, 1'b0, OP_A, 2);
    add_word(1'b0, OP_A, 1'b0, OP_A, 2);
    add_word(1'b0, OP_A, 1'b1, OP_A, 2);
    add_word(1'b0, OP_A, 1'b0, OP_A, 3);
    add_word(1'b0, OP_A, 1'b0, OP_A, 3);
    add_word(1'b0, OP_A, 1'b1, OP_A, 3);
    // Test 4: valid held high, B then C queued; C must wait for IDLE.
    add_idle(1'b1, OP_B, 1'b1);
    for (int k = 0; k < 4; k++) add_word(1'b1, OP_C, 1'b1, OP_B, k);
    add_idle(1'b1, OP_C, 1'b1);
    for (int k = 0; k < 4; k++) add_word(1'b0, OP_C, 1'b1, OP_C, k);
    add_idle(1'b0, OP_C, 1'b1);

    // Test 1: reset, then idle for 5 cycles.
    rst_n_in      = 1'b0;
    data_in       = 128'h0;
    data_valid_in = 1'b0;
    word_ready_in = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset.word", word_out, 32'h0);
    chk("reset.index", 32'(word_index_out), 32'd0);
    #20;
    rst_n_in = 1'b1;
    repeat (5) tick();
    chk_idle("idle5");

    // Table-driven tests 2..4 (and 6 when MSW-first is built).
    for (int i = 0; i < nv; i++) begin
      data_valid_in = vt[i].dv;
      data_in       = vt[i].data;
      word_ready_in = vt[i].wr;
      chk($sformatf("v%0d.ready", i), 32'(data_ready_out), 32'(vt[i].e_ready));
      chk($sformatf("v%0d.valid", i), 32'(word_valid_out), 32'(vt[i].e_valid));
      chk($sformatf("v%0d.busy",  i), 32'(busy_out),       32'(vt[i].e_busy));
      chk($sformatf("v%0d.last",  i), 32'(word_last_out),  32'(vt[i].e_last));
      chk($sformatf("v%0d.index", i), 32'(word_index_out), 32'(vt[i].e_idx));
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d.word", i), word_out, vt[i].e_word);
      end
      tick();
    end

    // Test 5: async reset after the word 1 handshake.
    data_valid_in = 1'b1;
    data_in       = OP_A;
    word_ready_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    tick();
    tick();
    chk("rst.pre_index", 32'(word_index_out), 32'd2);
    chk("rst.pre_word",  word_out, word_of(OP_A, 2));
    #2;
    rst_n_in = 1'b0;
    #1;
    chk_idle("rst.mid");
    chk("rst.index", 32'(word_index_out), 32'd0);
    #3;
    rst_n_in = 1'b1;
    tick();
    data_valid_in = 1'b1;
    data_in       = OP_B;
    chk_idle("rst.after");
    tick();
    data_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst.w%0d.valid", k), 32'(word_valid_out), 32'd1);
      chk($sformatf("rst.w%0d.word",  k), word_out, word_of(OP_B, k));
      chk($sformatf("rst.w%0d.index", k), 32'(word_index_out), 32'(k));
      chk($sformatf("rst.w%0d.last",  k), 32'(word_last_out), 32'(k == 3));
      tick();
    end
    chk_idle("rst.done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
